vend_controller: RTL

- Sequences the vending datapath: accumulates coin credit, validates a product selection against price and stock, drives the dispenser handshake, then returns change one 1-rupee coin at a time.
- Sits between the coin acceptor / keypad front end and the dispenser and change-hopper actuators.
- Replaces the fixed-price 3-rupee credit FSM with a multi-product, priced, refundable controller.

---
 rtl/vend_pkg.sv | 26 ++
 rtl/vend_timeout_ctr.sv | 30 +++
 rtl/vend_controller.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/vend_pkg.sv
// rtl/vend_pkg.sv - shared types, coin encodings and helpers for the vending controller
package vend_pkg;

  localparam int DEF_CREDIT_W = 4;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CREDIT   = 2'd1,
    DISPENSE = 2'd2,
    CHANGE   = 2'd3
  } state_t;

  localparam logic [1:0] COIN_NONE = 2'b00;
  localparam logic [1:0] COIN_1    = 2'b01;
  localparam logic [1:0] COIN_2    = 2'b10;

  // Invalid encodings map to zero so callers can treat "no value" as a reject.
  function automatic logic [DEF_CREDIT_W-1:0] coin_value(input logic [1:0] cv);
    case (cv)
      COIN_1:  return DEF_CREDIT_W'(1);
      COIN_2:  return DEF_CREDIT_W'(2);
      default: return '0;
    endcase
  endfunction

endpackage

// File: rtl/vend_timeout_ctr.sv
// rtl/vend_timeout_ctr.sv - loadable idle up-counter with terminal-count flag
module vend_timeout_ctr #(
  parameter  int TIMEOUT_CYC = 1000,
  localparam int CNT_W       = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  output logic             tc
);

  logic [CNT_W-1:0] count;

  assign tc = (count == CNT_W'(TIMEOUT_CYC - 1));

  // Holds at terminal count so a stalled consumer never sees it wrap back to zero.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && !tc) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/vend_controller.sv
// rtl/vend_controller.sv - multi-product vending sequencer: credit, select, dispense, change
module vend_controller
  import vend_pkg::*;
#(
  parameter  int                           NUM_PROD    = 4,
  parameter  int                           CREDIT_W    = 4,
  parameter  int                           MAX_CREDIT  = 9,
  parameter  logic [NUM_PROD*CREDIT_W-1:0] PRICES      = {4'd5, 4'd4, 4'd3, 4'd2},
  parameter  int                           TIMEOUT_CYC = 1000,
  localparam int                           SEL_W       = (NUM_PROD > 1) ? $clog2(NUM_PROD) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                coin_valid,
  input  logic [1:0]          coin_val,
  output logic                coin_reject,
  input  logic                sel_valid,
  input  logic [SEL_W-1:0]    sel_id,
  input  logic                cancel,
  input  logic [NUM_PROD-1:0] stock_empty,
  output logic                sel_error,
  output logic                disp_req,
  output logic [SEL_W-1:0]    disp_id,
  input  logic                disp_ack,
  output logic                change_req,
  input  logic                change_ack,
  output logic [CREDIT_W-1:0] credit,
  output logic                busy
);

  if (MAX_CREDIT >= (1 << CREDIT_W)) begin : g_credit_range_check
    $error("MAX_CREDIT does not fit in CREDIT_W bits");
  end

  state_t              state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [SEL_W-1:0]    disp_id_q, disp_id_d;
  logic                coin_reject_q, coin_reject_d;
  logic                sel_error_q, sel_error_d;
  logic                to_load, to_tc;

  logic [CREDIT_W:0]   coin_amt, coin_sum;
  logic                coin_ok;
  logic [CREDIT_W-1:0] price;
  logic                sel_ok;

  // One extra bit on the sum keeps the ceiling compare free of wrap-around.
  assign coin_amt = (CREDIT_W+1)'(coin_value(coin_val));
  assign coin_sum = {1'b0, credit_q} + coin_amt;
  assign coin_ok  = (coin_amt != '0) && (coin_sum <= (CREDIT_W+1)'(MAX_CREDIT));
  assign price    = PRICES[sel_id*CREDIT_W +: CREDIT_W];
  assign sel_ok   = !stock_empty[sel_id] && (credit_q >= price);

  vend_timeout_ctr #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clr     (state_q != CREDIT),
    .load    (to_load),
    .load_val('0),
    .en      (state_q == CREDIT),
    .tc      (to_tc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      credit_q      <= '0;
      disp_id_q     <= '0;
      coin_reject_q <= 1'b0;
      sel_error_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      credit_q      <= credit_d;
      disp_id_q     <= disp_id_d;
      coin_reject_q <= coin_reject_d;
      sel_error_q   <= sel_error_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    credit_d      = credit_q;
    disp_id_d     = disp_id_q;
    coin_reject_d = 1'b0;
    sel_error_d   = 1'b0;
    to_load       = 1'b0;
    case (state_q)
      IDLE: begin
        sel_error_d = sel_valid;
        if (coin_valid) begin
          if (coin_ok) begin
            credit_d = coin_sum[CREDIT_W-1:0];
            state_d  = CREDIT;
            to_load  = 1'b1;
          end else begin
            coin_reject_d = 1'b1;
          end
        end
      end
      CREDIT: begin
        // Timeout is an implicit cancel; both outrank selection, which outranks coins.
        if ((cancel && credit_q != '0) || to_tc) begin
          state_d       = CHANGE;
          coin_reject_d = coin_valid;
        end else if (sel_valid && sel_ok) begin
          credit_d      = credit_q - price;
          disp_id_d     = sel_id;
          state_d       = DISPENSE;
          coin_reject_d = coin_valid;
        end else begin
          if (sel_valid) begin
            sel_error_d = 1'b1;
            to_load     = 1'b1;
          end
          if (coin_valid) begin
            if (coin_ok) begin
              credit_d = coin_sum[CREDIT_W-1:0];
              to_load  = 1'b1;
            end else begin
              coin_reject_d = 1'b1;
            end
          end
        end
      end
      DISPENSE: begin
        coin_reject_d = coin_valid;
        if (disp_ack) begin
          state_d = (credit_q != '0) ? CHANGE : IDLE;
        end
      end
      CHANGE: begin
        coin_reject_d = coin_valid;
        if (change_ack) begin
          credit_d = credit_q - 1'b1;
          if (credit_q == CREDIT_W'(1)) begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign coin_reject = coin_reject_q;
  assign sel_error   = sel_error_q;
  assign disp_req    = (state_q == DISPENSE);
  assign disp_id     = disp_id_q;
  assign change_req  = (state_q == CHANGE) && (credit_q != '0);
  assign credit      = credit_q;
  assign busy        = (state_q == DISPENSE) || (state_q == CHANGE);

endmodule
